// File: rtl/mlp_hidden_accum.sv
// Hidden-layer accumulator for the O/X MLP: streams one binary pixel per handshake
// into N signed accumulators and publishes the pre-ReLU sums with a one-cycle valid.
module mlp_hidden_accum #(
    parameter int W     = 8,
    parameter int N     = 8,
    parameter int P     = 9,
    parameter int IDX_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 px_valid,
    input  logic                 px_data,
    output logic                 px_ready,
    output logic [IDX_W-1:0]     px_idx,
    input  logic [N*W-1:0]       w_h_bus,
    input  logic [N*W-1:0]       b_h_bus,
    output logic [N*(W+5)-1:0]   h_raw_bus,
    output logic                 h_valid,
    output logic                 busy
);

    localparam int ACC_W = W + 5;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(P - 1);

    logic [1:0]              state;
    logic signed [ACC_W-1:0] acc     [N];
    logic signed [ACC_W-1:0] acc_sum [N];
    logic                    beat;

    function automatic logic signed [ACC_W-1:0] sext(input logic [W-1:0] v);
        return {{(ACC_W - W){v[W-1]}}, v};
    endfunction

    assign px_ready = (state == S_ACCUM);
    assign h_valid  = (state == S_DONE);
    assign busy     = (state != S_IDLE);
    assign beat     = px_valid && px_ready;

    // Sum including the current beat; also feeds h_raw_bus on the last pixel.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            acc_sum[i] = acc[i];
            if (px_data) begin
                acc_sum[i] = acc[i] + sext(w_h_bus[i*W +: W]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            px_idx    <= '0;
            h_raw_bus <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                acc[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_ACCUM;
                        px_idx <= '0;
                        for (int unsigned i = 0; i < N; i++) begin
                            acc[i] <= sext(b_h_bus[i*W +: W]);
                        end
                    end
                end
                S_ACCUM: begin
                    if (beat) begin
                        for (int unsigned i = 0; i < N; i++) begin
                            acc[i] <= acc_sum[i];
                        end
                        if (px_idx == LAST_IDX) begin
                            state <= S_DONE;
                            for (int unsigned i = 0; i < N; i++) begin
                                h_raw_bus[i*ACC_W +: ACC_W] <= acc_sum[i];
                            end
                        end else begin
                            px_idx <= px_idx + IDX_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
